vga_timing_engine: RTL
======================

Name: vga_timing_engine

Overview:
- 640x480@60 Hz raster generator, derived from the 50 MHz system clock.
- Sits directly downstream of the quadrant colour-register block. It publishes the current pixel coordinate to that block, which returns 32-bit colour data combinationally.
- Drives the VGA DAC pins: 10-bit R/G/B, pixel clock, BLANK_N, SYNC_N, HSync and VSync.
- Also emits a one-clock start-of-frame strobe for upstream use.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- iClk_50  input  1  50 MHz system clock
- nRst  input  1  asynchronous active-low reset
- iVGA_colorData  input  32  colour for oVGA_colorAddress: [29:20]=R, [19:10]=G, [9:0]=B, [31:30] ignored
- oVGA_colorAddress  output  32  {Y[15:0], X[15:0]} of current counters
- oVGA_R  output  10  red to DAC
- oVGA_G  output  10  green to DAC
- oVGA_B  output  10  blue to DAC
- oVGA_Clk  output  1  25 MHz pixel clock to DAC
- oVGA_Blank  output  1  BLANK_N: 1 = visible pixel
- oVGA_HSync  output  1  horizontal sync, active low
- oVGA_VSync  output  1  vertical sync, active low
- oVGA_Sync  output  1  SYNC_N to DAC, tied 0 (no sync-on-green)
- oFrameStart  output  1  one-iClk_50 pulse at the tick where X=0, Y=0

Behaviour:
- Clock and reset: single clock domain, iClk_50. nRst asserted (0) clears all state immediately, mid-frame included. Counting restarts at X=0, Y=0 after release.
- Reset values:
  - ce=0, X=0, Y=0
  - oVGA_R/G/B=0, oVGA_Blank=0
  - oVGA_HSync=1, oVGA_VSync=1
  - oVGA_Clk=0, oFrameStart=0, oVGA_Sync=0
- Pixel enable:
  - ce toggles every iClk_50 cycle; pixel tick = (ce==1).
  - oVGA_Clk = ce register. Outputs change on the edge that ends a tick, oVGA_Clk falls on that same edge, and the DAC samples on the next rising edge (20 ns setup).
- Counters:
  - Only on a tick: X increments. When X = H_TOTAL-1 (799), X wraps to 0 and Y increments.
  - When Y = V_TOTAL-1 (524) at the X wrap, Y wraps to 0.
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is the same sum over the V_ parameters.
  - X and Y are 16-bit, zero-extended; they never exceed 799/524.
- Address: oVGA_colorAddress = {Y, X}, combinational from the counter registers. Valid for the whole pixel period. Also driven during blanking; the data is ignored there.
- Output stage: one pixel of latency. On each tick, sample the current counters and iVGA_colorData:
  - visible = (X < H_VISIBLE) && (Y < V_VISIBLE)
  - oVGA_R/G/B = visible ? data fields : 0
  - oVGA_Blank = visible
  - oVGA_HSync = ~(X >= H_VISIBLE+H_FRONT && X < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for X in 656..751
  - oVGA_VSync = ~(Y >= V_VISIBLE+V_FRONT && Y < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for Y in 490..491
  - RGB, blank and syncs stay mutually aligned.
- Between ticks every output register holds its value.
- oFrameStart is registered: high for exactly one iClk_50 cycle, following the tick at which the counters were (0,0). Exactly one pulse per 840000 clocks.
- Upstream data is assumed stable for the full 2-clock pixel period. No handshake; the block never stalls.

Decomposition:
- Package vga_pkg holds:
  - default timing constants and derived H_TOTAL/V_TOTAL
  - colour field bit positions (R_MSB/LSB, G, B)
  - the address packing helper {Y, X}
- Sub-module vga_axis_counter: parameterised modulo counter (TOTAL, VISIBLE, SYNC_START, SYNC_END) with inputs tick and wrap_in, and outputs count, wrap_out, active and sync_n. Instantiated twice, once for H and once for V, with the H wrap_out driving the V tick.

Test Plan:
- Reset then release:
  - during reset: all outputs at their reset values
  - first tick after release: oVGA_colorAddress=0 → 1, oFrameStart pulses once, oVGA_Clk toggles every cycle
- Line timing:
  - oVGA_HSync goes low when the registered X=656 and is low for exactly 96 ticks (192 clocks)
  - HSync period 1600 clocks; oVGA_Blank high for 640 ticks per line
- Frame timing:
  - oVGA_VSync low for exactly 2 lines (3200 clocks) starting at Y=490
  - oFrameStart period is exactly 840000 clocks
  - Y never exceeds 524
- Colour path and masking:
  - drive iVGA_colorData=32'hC_3FF_00_1 pattern as 0xFFF00401 → oVGA_R=10'h3FF, G=10'h001, B=10'h001 in the visible region, with [31:30] ignored
  - at X=640..799, or on any line with Y>=480, R/G/B=0 and oVGA_Blank=0
- Latency: a testbench model returning data = oVGA_colorAddress (X in B field) → the B output lags the address by exactly one pixel (2 clocks), and the first visible B=0 coincides with oVGA_Blank rising.
- Mid-frame reset: assert nRst at X=300, Y=200 → all outputs return to reset values asynchronously, before the next clock edge. After release the counters restart from (0,0) and oFrameStart pulses.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster generator:
//   - default 640x480@60 Hz timing constants and the derived line/frame totals
//   - bit positions of the R/G/B fields inside the 32-bit colour word
//   - helper that packs a {Y, X} coordinate into the 32-bit colour address
// -----------------------------------------------------------------------------
package vga_pkg;

   // Horizontal timing, in pixels
   localparam logic [15:0] H_VISIBLE = 16'd640;
   localparam logic [15:0] H_FRONT   = 16'd16;
   localparam logic [15:0] H_SYNC    = 16'd96;
   localparam logic [15:0] H_BACK    = 16'd48;
   localparam logic [15:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   // Vertical timing, in lines
   localparam logic [15:0] V_VISIBLE = 16'd480;
   localparam logic [15:0] V_FRONT   = 16'd10;
   localparam logic [15:0] V_SYNC    = 16'd2;
   localparam logic [15:0] V_BACK    = 16'd33;
   localparam logic [15:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Colour word layout: [31:30] unused, then R, G, B (10 bits each)
   localparam int COLOR_W = 10;
   localparam int R_MSB   = 29;
   localparam int R_LSB   = 20;
   localparam int G_MSB   = 19;
   localparam int G_LSB   = 10;
   localparam int B_MSB   = 9;
   localparam int B_LSB   = 0;

   // Channel index 0 = B, 1 = G, 2 = R, matching their order in the word
   function automatic int channel_lsb(input int ch);
      case (ch)
         0:       return B_LSB;
         1:       return G_LSB;
         default: return R_LSB;
      endcase
   endfunction

   function automatic logic [31:0] pack_address(input logic [15:0] y,
                                                input logic [15:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a modulo-TOTAL counter plus its visible and sync decodes.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   tick         advance request for this axis
//   wrap_in      carry-in; the counter advances only when tick && wrap_in
//   count        current position, 0 .. TOTAL-1
//   wrap_out     high in the cycle the counter steps from TOTAL-1 back to 0
//   active       count < VISIBLE
//   sync_n       low while SYNC_START <= count < SYNC_END
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter logic [15:0] TOTAL      = H_TOTAL,
   parameter logic [15:0] VISIBLE    = H_VISIBLE,
   parameter logic [15:0] SYNC_START = H_VISIBLE + H_FRONT,
   parameter logic [15:0] SYNC_END   = H_VISIBLE + H_FRONT + H_SYNC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        wrap_in,
   output logic [15:0] count,
   output logic        wrap_out,
   output logic        active,
   output logic        sync_n
);

   logic [15:0] count_reg;
   logic        advance;
   logic        at_last;

   assign advance  = tick & wrap_in;
   assign at_last  = (count_reg == TOTAL - 16'd1);
   assign wrap_out = advance & at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (advance) begin
         count_reg <= at_last ? 16'd0 : count_reg + 16'd1;
      end
   end

   assign count  = count_reg;
   assign active = (count_reg < VISIBLE);
   assign sync_n = ~((count_reg >= SYNC_START) && (count_reg < SYNC_END));

endmodule

// File: rtl/vga_timing_engine.sv
// -----------------------------------------------------------------------------
// vga_timing_engine
// 640x480@60 Hz raster generator running from the 50 MHz system clock with a
// 25 MHz pixel enable. Publishes the current {Y, X} to the colour source and
// registers the returned colour, blank and syncs one pixel later for the DAC.
// Ports:
//   iClk_50            50 MHz system clock
//   nRst               asynchronous active-low reset
//   iVGA_colorData     colour for oVGA_colorAddress ([29:20]R [19:10]G [9:0]B)
//   oVGA_colorAddress  {Y[15:0], X[15:0]} of the live counters
//   oVGA_R/G/B         10-bit colour to DAC, zero outside the visible area
//   oVGA_Clk           25 MHz pixel clock (the pixel-enable register)
//   oVGA_Blank         BLANK_N, high on visible pixels
//   oVGA_HSync         horizontal sync, active low
//   oVGA_VSync         vertical sync, active low
//   oVGA_Sync          SYNC_N, tied low (no sync-on-green)
//   oFrameStart        one-clock pulse after the tick at (0,0)
// -----------------------------------------------------------------------------
module vga_timing_engine
   import vga_pkg::*;
#(
   parameter logic [15:0] H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter logic [15:0] H_FRONT   = vga_pkg::H_FRONT,
   parameter logic [15:0] H_SYNC    = vga_pkg::H_SYNC,
   parameter logic [15:0] H_BACK    = vga_pkg::H_BACK,
   parameter logic [15:0] V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter logic [15:0] V_FRONT   = vga_pkg::V_FRONT,
   parameter logic [15:0] V_SYNC    = vga_pkg::V_SYNC,
   parameter logic [15:0] V_BACK    = vga_pkg::V_BACK
) (
   input  logic        iClk_50,
   input  logic        nRst,
   input  logic [31:0] iVGA_colorData,
   output logic [31:0] oVGA_colorAddress,
   output logic [9:0]  oVGA_R,
   output logic [9:0]  oVGA_G,
   output logic [9:0]  oVGA_B,
   output logic        oVGA_Clk,
   output logic        oVGA_Blank,
   output logic        oVGA_HSync,
   output logic        oVGA_VSync,
   output logic        oVGA_Sync,
   output logic        oFrameStart
);

   localparam logic [15:0] LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam logic [15:0] FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   logic        ce_reg;
   logic        pix_tick;
   logic [15:0] x_count;
   logic [15:0] y_count;
   logic        h_wrap;
   logic        h_active;
   logic        v_active;
   logic        h_sync_n;
   logic        v_sync_n;
   logic        v_wrap_unused;
   logic [1:0]  color_top_unused;
   logic        visible;
   logic        blank_reg;
   logic        hsync_reg;
   logic        vsync_reg;
   logic        frame_start_reg;
   logic [29:0] rgb_bus;

   // ce alternates every system clock; the cycle it is high is the pixel tick,
   // so the counters and the output stage move on the edge where oVGA_Clk falls.
   always_ff @(posedge iClk_50 or negedge nRst) begin
      if (!nRst) begin
         ce_reg <= 1'b0;
      end else begin
         ce_reg <= ~ce_reg;
      end
   end

   assign pix_tick = ce_reg;

   vga_axis_counter #(
      .TOTAL      (LINE_TOTAL),
      .VISIBLE    (H_VISIBLE),
      .SYNC_START (H_VISIBLE + H_FRONT),
      .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC)
   ) u_h_counter (
      .clk      (iClk_50),
      .rst_n    (nRst),
      .tick     (pix_tick),
      .wrap_in  (1'b1),
      .count    (x_count),
      .wrap_out (h_wrap),
      .active   (h_active),
      .sync_n   (h_sync_n)
   );

   // The vertical axis steps once per line, on the horizontal wrap.
   vga_axis_counter #(
      .TOTAL      (FRAME_LINES),
      .VISIBLE    (V_VISIBLE),
      .SYNC_START (V_VISIBLE + V_FRONT),
      .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC)
   ) u_v_counter (
      .clk      (iClk_50),
      .rst_n    (nRst),
      .tick     (h_wrap),
      .wrap_in  (1'b1),
      .count    (y_count),
      .wrap_out (v_wrap_unused),
      .active   (v_active),
      .sync_n   (v_sync_n)
   );

   assign oVGA_colorAddress = pack_address(y_count, x_count);
   assign visible           = h_active & v_active;
   assign color_top_unused  = iVGA_colorData[31:30];

   // Colour channels share one template; rgb_bus keeps the input word layout.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         localparam int LSB = channel_lsb(gi);
         logic [COLOR_W-1:0] chan_reg;

         always_ff @(posedge iClk_50 or negedge nRst) begin
            if (!nRst) begin
               chan_reg <= '0;
            end else if (pix_tick) begin
               chan_reg <= visible ? iVGA_colorData[LSB +: COLOR_W] : '0;
            end
         end

         assign rgb_bus[gi*COLOR_W +: COLOR_W] = chan_reg;
      end
   endgenerate

   // Blank and syncs are sampled on the same tick as the colour so all DAC
   // signals describe the same pixel.
   always_ff @(posedge iClk_50 or negedge nRst) begin
      if (!nRst) begin
         blank_reg       <= 1'b0;
         hsync_reg       <= 1'b1;
         vsync_reg       <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= pix_tick && (x_count == 16'd0) && (y_count == 16'd0);
         if (pix_tick) begin
            blank_reg <= visible;
            hsync_reg <= h_sync_n;
            vsync_reg <= v_sync_n;
         end
      end
   end

   assign oVGA_R      = rgb_bus[R_MSB:R_LSB];
   assign oVGA_G      = rgb_bus[G_MSB:G_LSB];
   assign oVGA_B      = rgb_bus[B_MSB:B_LSB];
   assign oVGA_Clk    = ce_reg;
   assign oVGA_Blank  = blank_reg;
   assign oVGA_HSync  = hsync_reg;
   assign oVGA_VSync  = vsync_reg;
   assign oVGA_Sync   = 1'b0;
   assign oFrameStart = frame_start_reg;

endmodule
